perm_cost_eval: RTL and testbench

- Downstream consumer of the lexicographic permutation generator in the job-assignment engine.
- For each offered 8-entry worker->job arrangement it does the following:
  - drives W/J addresses to the external cost table, one worker per cycle;
  - accumulates the eight costs;
  - keeps a running minimum total and a count of arrangements that hit that minimum.
- The top-level FSM steps permutations with a start/ready handshake and raises Valid once `last` has been evaluated.

---
 rtl/perm_cost_eval_if.sv | 43 ++++
 rtl/perm_cost_eval.sv | 105 ++++++++++
 tb/tb_perm_cost_eval.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/perm_cost_eval_if.sv
// Handshake and cost-table bus between the permutation generator/cost table
// and the arrangement cost evaluator.
interface perm_cost_eval_if #(
   parameter int COST_W = 7,
   parameter int SUM_W  = 10,
   parameter int MCNT_W = 4
);
   logic              clr;
   logic              start;
   logic              last;
   logic [2:0]        arrange0;
   logic [2:0]        arrange1;
   logic [2:0]        arrange2;
   logic [2:0]        arrange3;
   logic [2:0]        arrange4;
   logic [2:0]        arrange5;
   logic [2:0]        arrange6;
   logic [2:0]        arrange7;
   logic              ready;
   logic [2:0]        W;
   logic [2:0]        J;
   logic [COST_W-1:0] Cost;
   logic              done;
   logic [SUM_W-1:0]  MinCost;
   logic [MCNT_W-1:0] MatchCount;
   logic              Valid;

   modport master (
      output clr, start, last,
      output arrange0, arrange1, arrange2, arrange3,
      output arrange4, arrange5, arrange6, arrange7,
      output Cost,
      input  ready, W, J, done, MinCost, MatchCount, Valid
   );

   modport slave (
      input  clr, start, last,
      input  arrange0, arrange1, arrange2, arrange3,
      input  arrange4, arrange5, arrange6, arrange7,
      input  Cost,
      output ready, W, J, done, MinCost, MatchCount, Valid
   );
endinterface

// File: rtl/perm_cost_eval.sv
// Evaluates the total cost of each offered worker->job arrangement and tracks
// the running minimum total and how many arrangements reached it.
module perm_cost_eval #(
   parameter int N_WORK = 8,
   parameter int COST_W = 7,
   parameter int SUM_W  = 10,
   parameter int MCNT_W = 4
) (
   input logic             CLK,
   input logic             RST,
   perm_cost_eval_if.slave bus
);
   localparam int IDX_W = $clog2(N_WORK);
   localparam logic [IDX_W-1:0] W_LAST = IDX_W'(N_WORK - 1);

   typedef enum logic [1:0] {IDLE, FETCH, UPDATE, FIN} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  arr_q [N_WORK];
   logic              last_q;
   logic [IDX_W-1:0]  w_q, j_q, w_nxt;
   logic [SUM_W-1:0]  acc_q, min_q;
   logic [MCNT_W-1:0] mcnt_q;
   logic              accept;

   function automatic logic [MCNT_W-1:0] sat_inc(input logic [MCNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   assign accept = (state_q == IDLE) && bus.start;
   assign w_nxt  = w_q + 1'b1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = FETCH;
         FETCH:   if (w_q == W_LAST) state_d = UPDATE;
         UPDATE:  state_d = last_q ? FIN : IDLE;
         FIN:     state_d = FIN;
         default: state_d = IDLE;
      endcase
   end

   // Arrangement capture stage: data only, qualified by the accept strobe
   always_ff @(posedge CLK) begin
      if (accept) begin
         arr_q[0] <= bus.arrange0;
         arr_q[1] <= bus.arrange1;
         arr_q[2] <= bus.arrange2;
         arr_q[3] <= bus.arrange3;
         arr_q[4] <= bus.arrange4;
         arr_q[5] <= bus.arrange5;
         arr_q[6] <= bus.arrange6;
         arr_q[7] <= bus.arrange7;
         last_q   <= bus.last;
      end
   end

   // Fetch/accumulate and result-update stage; clr restarts the search
   always_ff @(posedge CLK) begin
      if (RST || bus.clr) begin
         state_q <= IDLE;
         w_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         min_q   <= '1;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  w_q   <= '0;
                  j_q   <= bus.arrange0;
                  acc_q <= '0;
               end
            end
            FETCH: begin
               acc_q <= acc_q + {{(SUM_W-COST_W){1'b0}}, bus.Cost};
               if (w_q != W_LAST) begin
                  w_q <= w_nxt;
                  j_q <= arr_q[w_nxt];
               end
            end
            UPDATE: begin
               if (acc_q < min_q) begin
                  min_q  <= acc_q;
                  mcnt_q <= MCNT_W'(1);
               end else if (acc_q == min_q) begin
                  mcnt_q <= sat_inc(mcnt_q);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready      = (state_q == IDLE);
   assign bus.done       = (state_q == UPDATE);
   assign bus.Valid      = (state_q == FIN);
   assign bus.W          = w_q;
   assign bus.J          = j_q;
   assign bus.MinCost    = min_q;
   assign bus.MatchCount = mcnt_q;
endmodule

// File: tb/tb_perm_cost_eval.sv
// Bench for perm_cost_eval: directed vector table, handshake corner cases and
// randomized cost tables checked against a sum/min/count reference model.
module tb_perm_cost_eval;
   logic CLK = 1'b0;
   logic RST;

   perm_cost_eval_if bus ();

   perm_cost_eval dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   logic [6:0] cost_tab [8][8];
   always_comb bus.Cost = cost_tab[bus.W][bus.J];

   typedef struct {
      logic [7:0][2:0] arr;
      int              exp_min;
      int              exp_cnt;
   } vec_t;

   vec_t vecs [4];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_min;
   int   m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0][2:0] mk(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
      logic [7:0][2:0] r;
      r[0] = 3'(a0); r[1] = 3'(a1); r[2] = 3'(a2); r[3] = 3'(a3);
      r[4] = 3'(a4); r[5] = 3'(a5); r[6] = 3'(a6); r[7] = 3'(a7);
      return r;
   endfunction

   function automatic int model_total(input logic [7:0][2:0] a);
      int s = 0;
      for (int w = 0; w < 8; w++) s += int'(cost_tab[w][a[w]]);
      return s;
   endfunction

   task automatic model_reset();
      m_min = 1023;
      m_cnt = 0;
   endtask

   task automatic model_update(input int tot);
      if (tot < m_min) begin
         m_min = tot;
         m_cnt = 1;
      end else if (tot == m_min) begin
         m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end
   endtask

   task automatic set_tab_wj();
      for (int w = 0; w < 8; w++)
         for (int j = 0; j < 8; j++) cost_tab[w][j] = 7'(w + j);
   endtask

   task automatic set_tab_rand(input int hi);
      for (int w = 0; w < 8; w++)
         for (int j = 0; j < 8; j++) cost_tab[w][j] = 7'($urandom_range(0, hi));
   endtask

   task automatic drive_arr(input logic [7:0][2:0] a);
      bus.arrange0 = a[0]; bus.arrange1 = a[1]; bus.arrange2 = a[2]; bus.arrange3 = a[3];
      bus.arrange4 = a[4]; bus.arrange5 = a[5]; bus.arrange6 = a[6]; bus.arrange7 = a[7];
   endtask

   function automatic logic [7:0][2:0] rand_arr();
      logic [7:0][2:0] a;
      for (int w = 0; w < 8; w++) a[w] = 3'($urandom_range(0, 7));
      return a;
   endfunction

   // Called and returning at a negedge with the DUT idle.
   task automatic run_arr(input logic [7:0][2:0] a, input bit lst, input bit chk_wj);
      check("ready_before_start", bus.ready, 1);
      bus.start = 1'b1;
      bus.last  = lst;
      drive_arr(a);
      @(negedge CLK);
      bus.start = 1'b0;
      bus.last  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (chk_wj) begin
            check($sformatf("W_fetch%0d", k), bus.W, k);
            check($sformatf("J_fetch%0d", k), bus.J, a[k]);
            check($sformatf("done_fetch%0d", k), bus.done, 0);
            check($sformatf("ready_fetch%0d", k), bus.ready, 0);
         end
         @(negedge CLK);
      end
      check("done_update", bus.done, 1);
      model_update(model_total(a));
      @(negedge CLK);
      check("MinCost", bus.MinCost, m_min);
      check("MatchCount", bus.MatchCount, m_cnt);
      check("Valid_after", bus.Valid, lst);
      check("ready_after", bus.ready, !lst);
      check("done_after", bus.done, 0);
   endtask

   task automatic do_clr();
      bus.clr = 1'b1;
      @(negedge CLK);
      bus.clr = 1'b0;
      model_reset();
   endtask

   initial begin
      int dcount;
      RST = 1'b1;
      bus.clr = 1'b0;
      bus.start = 1'b0;
      bus.last = 1'b0;
      drive_arr('0);
      set_tab_wj();
      model_reset();
      repeat (2) @(negedge CLK);
      check("rst_ready", bus.ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_Valid", bus.Valid, 0);
      check("rst_MinCost", bus.MinCost, 1023);
      check("rst_MatchCount", bus.MatchCount, 0);
      check("rst_W", bus.W, 0);
      check("rst_J", bus.J, 0);
      RST = 1'b0;
      @(negedge CLK);

      vecs[0] = '{mk(0,1,2,3,4,5,6,7), 56, 1};
      vecs[1] = '{mk(7,6,5,4,3,2,1,0), 56, 2};
      vecs[2] = '{mk(0,1,2,3,4,5,6,1), 50, 1};
      vecs[3] = '{mk(3,1,2,3,4,5,7,7), 50, 1};
      for (int i = 0; i < 4; i++) begin
         run_arr(vecs[i].arr, 1'b0, 1'b1);
         check($sformatf("vec%0d_MinCost", i), bus.MinCost, vecs[i].exp_min);
         check($sformatf("vec%0d_MatchCount", i), bus.MatchCount, vecs[i].exp_cnt);
      end

      // Seventeen equal totals of 40: count saturates
      do_clr();
      for (int i = 0; i < 17; i++) run_arr(mk(0,0,0,0,0,0,6,6), 1'b0, 1'b0);
      check("sat_MinCost", bus.MinCost, 40);
      check("sat_MatchCount", bus.MatchCount, 15);

      // Final permutation: Valid sticks, further start ignored, clr restarts
      do_clr();
      run_arr(mk(0,1,2,3,4,5,6,7), 1'b1, 1'b0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         bus.start = 1'b1;
         drive_arr(rand_arr());
         @(negedge CLK);
         if (bus.done) dcount++;
      end
      bus.start = 1'b0;
      check("fin_no_done", dcount, 0);
      check("fin_Valid", bus.Valid, 1);
      check("fin_ready", bus.ready, 0);
      check("fin_MinCost", bus.MinCost, 56);
      check("fin_MatchCount", bus.MatchCount, 1);
      do_clr();
      check("clr_Valid", bus.Valid, 0);
      check("clr_MinCost", bus.MinCost, 1023);
      check("clr_MatchCount", bus.MatchCount, 0);
      check("clr_ready", bus.ready, 1);

      // Reset during the fourth fetch cycle aborts the arrangement
      run_arr(mk(1,1,1,1,1,1,1,1), 1'b0, 1'b0);
      bus.start = 1'b1;
      drive_arr(mk(0,1,2,3,4,5,6,7));
      @(negedge CLK);
      bus.start = 1'b0;
      dcount = 0;
      for (int k = 1; k <= 4; k++) begin
         if (bus.done) dcount++;
         if (k < 4) @(negedge CLK);
      end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      check("rstmid_ready", bus.ready, 1);
      check("rstmid_MinCost", bus.MinCost, 1023);
      check("rstmid_MatchCount", bus.MatchCount, 0);
      check("rstmid_W", bus.W, 0);
      for (int i = 0; i < 10; i++) begin
         if (bus.done) dcount++;
         @(negedge CLK);
      end
      check("rstmid_no_done", dcount, 0);

      // clr wins over a simultaneous start
      bus.clr = 1'b1;
      bus.start = 1'b1;
      @(negedge CLK);
      bus.clr = 1'b0;
      bus.start = 1'b0;
      check("clr_prio_ready", bus.ready, 1);
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.done) dcount++;
         @(negedge CLK);
      end
      check("clr_prio_no_done", dcount, 0);
      model_reset();

      // Maximum cost everywhere: 8*127 must not overflow
      for (int w = 0; w < 8; w++)
         for (int j = 0; j < 8; j++) cost_tab[w][j] = 7'd127;
      run_arr(rand_arr(), 1'b0, 1'b1);
      check("max_MinCost", bus.MinCost, 1016);
      check("max_MatchCount", bus.MatchCount, 1);

      // Randomized tables; narrow cost ranges provoke equal totals
      for (int r = 0; r < 4; r++) begin
         do_clr();
         set_tab_rand((r < 2) ? 2 : 127);
         for (int i = 0; i < 8; i++) run_arr(rand_arr(), 1'b0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
